// File: rtl/cam_stream_packer_if.sv
// cam_stream_packer_if: camera byte input, FIFO word output and status bundle for the packer.
interface cam_stream_packer_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_eof;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_burst_valid;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic [15:0] frame_cnt;
  modport master (
    output in_valid, in_data, in_eof, out_ready,
    input  out_data, out_valid, out_burst_valid, overflow, drop_cnt, frame_cnt
  );
  modport slave (
    input  in_valid, in_data, in_eof, out_ready,
    output out_data, out_valid, out_burst_valid, overflow, drop_cnt, frame_cnt
  );
endinterface

// File: rtl/cam_stream_packer.sv
// cam_stream_packer: packs camera bytes into 64-bit words, pads frames to whole bursts, buffers in a show-ahead FIFO.
module cam_stream_packer #(
  parameter int BURST_WORDS = 16,
  parameter int FIFO_DEPTH  = 64
) (
  input logic CLK,
  input logic RST,
  cam_stream_packer_if.slave bus
);
  localparam int BW = $clog2(BURST_WORDS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] BURST = (AW+1)'(BURST_WORDS);
  typedef enum logic {PACK, PAD} state_t;
  state_t          st;
  logic [2:0]      byte_idx;
  logic [63:0]     acc_word;
  logic [BW-1:0]   burst_pos, bp_next;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [63:0]     mem [FIFO_DEPTH];
  logic            pop, full, take, done, pad_push, pad_drop, drop_word, push;
  logic [63:0]     word;
  logic [3:0]      drop_n;
  logic [16:0]     drop_sum;
  always_comb begin
    pop       = count != '0 && bus.out_ready;
    full      = count == DEPTH;
    take      = bus.in_valid && st == PACK;
    done      = take && (byte_idx == 3'd7 || bus.in_eof);
    pad_push  = st == PAD && (!full || pop);
    pad_drop  = bus.in_valid && st == PAD;
    drop_word = done && full && !pop;
    push      = pad_push || (done && !drop_word);
    word      = st == PAD ? 64'd0 : acc_word | (64'(bus.in_data) << {byte_idx, 3'd0});
    drop_n    = drop_word ? {1'b0, byte_idx} + 4'd1 : {3'd0, pad_drop};
    drop_sum  = {1'b0, bus.drop_cnt} + 17'(drop_n);
    bp_next   = burst_pos + BW'(1);
  end
  // burst_pos advances even for dropped words so padding stays burst-aligned
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st            <= PACK;
      byte_idx      <= '0;
      acc_word      <= '0;
      burst_pos     <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      bus.overflow  <= 1'b0;
      bus.drop_cnt  <= '0;
      bus.frame_cnt <= '0;
    end else begin
      if (take) begin
        byte_idx <= done ? 3'd0 : byte_idx + 3'd1;
        acc_word <= done ? 64'd0 : word;
      end
      if (done || pad_push) burst_pos <= bp_next;
      if ((done && bus.in_eof) || pad_push) begin
        st <= bp_next == '0 ? PACK : PAD;
        if (bp_next == '0) bus.frame_cnt <= bus.frame_cnt + 16'd1;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (drop_n != '0) begin
        bus.overflow <= 1'b1;
        bus.drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
    end
  end
  always_ff @(posedge CLK) if (push) mem[wr_ptr] <= word;
  assign bus.out_data        = mem[rd_ptr];
  assign bus.out_valid       = count != '0;
  assign bus.out_burst_valid = count >= BURST;
endmodule

// File: tb/tb_cam_stream_packer.sv
// tb_cam_stream_packer: randomized checks of cam_stream_packer against a byte/word queue reference model.
module tb_cam_stream_packer;
  localparam int B = 16;
  localparam int DEPTH = 64;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errs = 0;
  int chks = 0;
  cam_stream_packer_if bus();
  cam_stream_packer #(.BURST_WORDS(B), .FIFO_DEPTH(DEPTH)) dut (.CLK(clk), .RST(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  logic [63:0] q[$];
  logic [7:0]  cur[$];
  int          m_pad, m_words, m_drop;
  logic        m_ovf;
  logic [15:0] m_frames;
  task automatic model_reset;
    q.delete();
    cur.delete();
    m_pad = 0;
    m_words = 0;
    m_drop = 0;
    m_ovf = 1'b0;
    m_frames = '0;
  endtask
  task automatic add_drop(input int n);
    m_drop = (m_drop + n > 65535) ? 65535 : m_drop + n;
    m_ovf = 1'b1;
  endtask
  function automatic logic [34:0] exp_st();
    return {q.size() > 0, q.size() >= B, m_ovf, m_drop[15:0], m_frames};
  endfunction
  // one clock: drive inputs, advance the reference model, settle past the edge
  task automatic step(input logic v, input logic [7:0] d, input logic e, input logic r);
    logic [63:0] w;
    bus.in_valid = v;
    bus.in_data = d;
    bus.in_eof = e;
    bus.out_ready = r;
    @(posedge clk);
    if (r && q.size() > 0) void'(q.pop_front());
    if (m_pad > 0) begin
      if (v) add_drop(1);
      if (q.size() < DEPTH) begin
        q.push_back(64'd0);
        m_pad--;
        if (m_pad == 0) m_frames++;
      end
    end else if (v) begin
      cur.push_back(d);
      if (cur.size() == 8 || e) begin
        w = '0;
        foreach (cur[i]) w[8*i +: 8] = cur[i];
        if (q.size() < DEPTH) q.push_back(w);
        else add_drop(cur.size());
        m_words++;
        cur.delete();
        if (e) begin
          if (m_words % B != 0) m_pad = B - m_words % B;
          else m_frames++;
          m_words = 0;
        end
      end
    end
    #1;
  endtask
  task automatic do_reset;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_eof = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask
  task automatic test_reset;
    do_reset();
    chks++;
    if ({bus.out_valid, bus.out_burst_valid, bus.overflow, bus.drop_cnt, bus.frame_cnt} !== 35'd0) begin
      errs++;
      $display("FAIL reset_state got %h want 0", {bus.out_valid, bus.out_burst_valid, bus.overflow, bus.drop_cnt, bus.frame_cnt});
    end
  endtask
  task automatic test_aligned_frame;
    do_reset();
    for (int i = 0; i < 128; i++) begin
      step(1'b1, 8'(i), i == 127, 1'b1);
      chks++;
      if ({bus.out_valid, bus.out_burst_valid, bus.overflow, bus.drop_cnt, bus.frame_cnt} !== exp_st()) begin
        errs++;
        $display("FAIL aligned_status i=%0d got %h want %h", i, {bus.out_valid, bus.out_burst_valid, bus.overflow, bus.drop_cnt, bus.frame_cnt}, exp_st());
      end
      if (q.size() > 0) begin
        chks++;
        if (bus.out_data !== q[0]) begin
          errs++;
          $display("FAIL aligned_data i=%0d got %h want %h", i, bus.out_data, q[0]);
        end
      end
      if (i == 7) begin
        chks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h0706050403020100) begin
          errs++;
          $display("FAIL first_word valid=%b got %h want 0706050403020100", bus.out_valid, bus.out_data);
        end
      end
    end
    repeat (3) step(1'b0, 8'd0, 1'b0, 1'b1);
    chks++;
    if (bus.frame_cnt !== 16'd1 || bus.drop_cnt !== 16'd0 || bus.out_valid !== 1'b0) begin
      errs++;
      $display("FAIL aligned_end frame=%0d drop=%0d valid=%b want 1 0 0", bus.frame_cnt, bus.drop_cnt, bus.out_valid);
    end
  endtask
  task automatic test_pad;
    logic [7:0] b[20];
    do_reset();
    for (int i = 0; i < 20; i++) begin
      b[i] = 8'($urandom);
      step(1'b1, b[i], i == 19, 1'b0);
    end
    for (int c = 1; c <= 13; c++) begin
      step(1'b0, 8'd0, 1'b0, 1'b0);
      chks++;
      if ({bus.out_valid, bus.out_burst_valid, bus.overflow, bus.drop_cnt, bus.frame_cnt} !== exp_st()) begin
        errs++;
        $display("FAIL pad_status c=%0d got %h want %h", c, {bus.out_valid, bus.out_burst_valid, bus.overflow, bus.drop_cnt, bus.frame_cnt}, exp_st());
      end
      if (c == 12) begin
        chks++;
        if (bus.out_burst_valid !== 1'b0 || bus.frame_cnt !== 16'd0) begin
          errs++;
          $display("FAIL pad_early burst=%b frame=%0d want 0 0", bus.out_burst_valid, bus.frame_cnt);
        end
      end
      if (c == 13) begin
        chks++;
        if (bus.out_burst_valid !== 1'b1 || bus.frame_cnt !== 16'd1) begin
          errs++;
          $display("FAIL pad_done burst=%b frame=%0d want 1 1", bus.out_burst_valid, bus.frame_cnt);
        end
      end
    end
    for (int k = 0; k < 16; k++) begin
      chks++;
      if (bus.out_data !== q[0]) begin
        errs++;
        $display("FAIL pad_data k=%0d got %h want %h", k, bus.out_data, q[0]);
      end
      if (k == 2) begin
        chks++;
        if (bus.out_data !== {32'h0, b[19], b[18], b[17], b[16]}) begin
          errs++;
          $display("FAIL partial_word got %h want %h", bus.out_data, {32'h0, b[19], b[18], b[17], b[16]});
        end
      end
      step(1'b0, 8'd0, 1'b0, 1'b1);
    end
    chks++;
    if (bus.out_valid !== 1'b0) begin
      errs++;
      $display("FAIL pad_drained valid=%b want 0", bus.out_valid);
    end
  endtask
  task automatic test_overflow;
    do_reset();
    for (int i = 0; i < 560; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    chks++;
    if (bus.drop_cnt !== 16'd48 || bus.overflow !== 1'b1 || bus.out_burst_valid !== 1'b1) begin
      errs++;
      $display("FAIL overflow_fill drop=%0d ovf=%b burst=%b want 48 1 1", bus.drop_cnt, bus.overflow, bus.out_burst_valid);
    end
    for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), 1'b0, i == 7);
    chks++;
    if ({bus.out_valid, bus.out_burst_valid, bus.overflow, bus.drop_cnt, bus.frame_cnt} !== exp_st() || bus.drop_cnt !== 16'd48) begin
      errs++;
      $display("FAIL full_push_pop got %h want %h", {bus.out_valid, bus.out_burst_valid, bus.overflow, bus.drop_cnt, bus.frame_cnt}, exp_st());
    end
    for (int k = 0; k < DEPTH; k++) begin
      chks++;
      if (bus.out_data !== q[0]) begin
        errs++;
        $display("FAIL drain_data k=%0d got %h want %h", k, bus.out_data, q[0]);
      end
      step(1'b0, 8'd0, 1'b0, 1'b1);
      chks++;
      if ({bus.out_valid, bus.out_burst_valid, bus.overflow, bus.drop_cnt, bus.frame_cnt} !== exp_st()) begin
        errs++;
        $display("FAIL drain_status k=%0d got %h want %h", k, {bus.out_valid, bus.out_burst_valid, bus.overflow, bus.drop_cnt, bus.frame_cnt}, exp_st());
      end
    end
  endtask
  task automatic test_pad_drop;
    int len, n;
    logic v;
    logic [63:0] w;
    do_reset();
    len = $urandom_range(3, 60);
    n = 0;
    for (int i = 0; i < len; i++) step(1'b1, 8'($urandom), i == len - 1, 1'b1);
    for (int c = 0; c < 2 * B && m_pad > 0; c++) begin
      v = 1'($urandom);
      if (v) n++;
      step(v, 8'($urandom), 1'($urandom), 1'b1);
    end
    chks++;
    if (bus.drop_cnt !== 16'(n) || bus.overflow !== (n > 0) || bus.frame_cnt !== 16'd1) begin
      errs++;
      $display("FAIL pad_drop drop=%0d ovf=%b frame=%0d want %0d %b 1", bus.drop_cnt, bus.overflow, bus.frame_cnt, n, n > 0);
    end
    for (int i = 0; i < 8; i++) begin
      w[8*i +: 8] = 8'($urandom);
      step(1'b1, w[8*i +: 8], 1'b0, 1'b1);
    end
    chks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== w) begin
      errs++;
      $display("FAIL after_pad_lane valid=%b got %h want %h", bus.out_valid, bus.out_data, w);
    end
  endtask
  task automatic test_random;
    int len;
    do_reset();
    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(1, 150);
      for (int i = 0; i < len + 20; i++) begin
        if (i < len) step(1'b1, 8'($urandom), i == len - 1, $urandom_range(0, 3) != 0);
        else step(m_pad > 0 && 1'($urandom), 8'($urandom), 1'b0, $urandom_range(0, 3) != 0);
        chks++;
        if ({bus.out_valid, bus.out_burst_valid, bus.overflow, bus.drop_cnt, bus.frame_cnt} !== exp_st()) begin
          errs++;
          $display("FAIL random_status f=%0d i=%0d got %h want %h", f, i, {bus.out_valid, bus.out_burst_valid, bus.overflow, bus.drop_cnt, bus.frame_cnt}, exp_st());
        end
        if (q.size() > 0) begin
          chks++;
          if (bus.out_data !== q[0]) begin
            errs++;
            $display("FAIL random_data f=%0d i=%0d got %h want %h", f, i, bus.out_data, q[0]);
          end
        end
      end
    end
  endtask
  task automatic test_reset_midframe;
    logic [63:0] w;
    do_reset();
    for (int i = 0; i < 132; i++) step(1'b1, 8'($urandom), i == 131, 1'b0);
    repeat (2) step(1'b0, 8'd0, 1'b0, 1'b0);
    chks++;
    if (bus.out_burst_valid !== 1'b1 || bus.out_valid !== 1'b1) begin
      errs++;
      $display("FAIL pre_reset burst=%b valid=%b want 1 1", bus.out_burst_valid, bus.out_valid);
    end
    #2 rst = 1'b1;
    #1;
    chks++;
    if (bus.out_valid !== 1'b0 || bus.out_burst_valid !== 1'b0 || bus.frame_cnt !== 16'd0) begin
      errs++;
      $display("FAIL async_reset valid=%b burst=%b frame=%0d want 0 0 0", bus.out_valid, bus.out_burst_valid, bus.frame_cnt);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      w[8*i +: 8] = 8'($urandom);
      step(1'b1, w[8*i +: 8], 1'b0, 1'b0);
    end
    chks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== w || bus.out_data !== q[0]) begin
      errs++;
      $display("FAIL post_reset_lane valid=%b got %h want %h", bus.out_valid, bus.out_data, w);
    end
  endtask
  initial begin
    model_reset();
    test_reset();
    test_aligned_frame();
    test_pad();
    test_overflow();
    test_pad_drop();
    test_random();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
